// File: rtl/result_tx_streamer_if.sv
// Bus between the result streamer, the output result memory and the UART TX path.
// Lane 0 of the read data sits in bits [15:0].
interface result_tx_streamer_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_rd_data;
    logic [7:0]        tx_data;
    logic              tx_en;
    logic              tx_done;

    modport master (
        output mem_addr,
        output tx_data,
        output tx_en,
        input  mem_rd_data,
        input  tx_done
    );

    modport slave (
        input  mem_addr,
        input  tx_data,
        input  tx_en,
        output mem_rd_data,
        output tx_done
    );
endinterface

// File: rtl/result_tx_streamer.sv
// Streams NUM_WORDS 64-bit output-memory words to the UART as 8 bytes each,
// lane 0 first and low byte first, one tx_en pulse per byte gated by tx_done.
module result_tx_streamer #(
    parameter int unsigned NUM_WORDS = 8192,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    result_tx_streamer_if.master   bus,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [31:0]            o_byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_LATCH,
        S_SEND,
        S_WAIT_TX,
        S_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [63:0]       r_buf;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_next;
    logic [7:0]        r_tx_data;
    logic              r_tx_en;
    logic              r_busy;
    logic              r_done;
    logic [31:0]       r_byte_count;
    logic              w_last_byte;
    logic              w_last_addr;
    logic              w_accept_done;

    assign w_last_byte   = (r_idx == 3'd7);
    assign w_last_addr   = (r_mem_addr == LAST_ADDR);
    assign w_accept_done = (r_state == S_WAIT_TX) && bus.tx_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH:   w_next = S_WAIT_RD;
            S_WAIT_RD: begin
                w_next     = S_LATCH;
                w_idx_next = 3'd0;
            end
            S_LATCH:   w_next = S_SEND;
            S_SEND:    w_next = S_WAIT_TX;
            S_WAIT_TX: begin
                if (bus.tx_done) begin
                    if (!w_last_byte) begin
                        w_next     = S_SEND;
                        w_idx_next = r_idx + 3'd1;
                    end else if (!w_last_addr) begin
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_FIN;
                    end
                end
            end
            S_FIN:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so tx_en/done/busy line up
    // with the SEND/FIN cycles and tx_data is loaded on SEND entry only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_addr   <= '0;
            r_buf        <= '0;
            r_idx        <= '0;
            r_tx_data    <= '0;
            r_tx_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_byte_count <= '0;
        end else begin
            r_idx   <= w_idx_next;
            r_tx_en <= (w_next == S_SEND);
            r_done  <= (w_next == S_FIN);
            r_busy  <= (w_next != S_IDLE);
            if (w_next == S_SEND) begin
                r_tx_data <= r_buf[{w_idx_next, 3'b000} +: 8];
            end
            if (r_state == S_WAIT_RD) begin
                r_buf <= bus.mem_rd_data;
            end
            if ((r_state == S_IDLE) && i_start) begin
                r_mem_addr   <= '0;
                r_byte_count <= '0;
            end
            if (w_accept_done) begin
                r_byte_count <= r_byte_count + 32'd1;
                if (w_last_byte && !w_last_addr) begin
                    r_mem_addr <= r_mem_addr + 1'b1;
                end
            end
        end
    end

    assign bus.mem_addr = r_mem_addr;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_en    = r_tx_en;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_byte_count = r_byte_count;

endmodule

// File: tb/tb_result_tx_streamer.sv
// Bench for result_tx_streamer: two instances (1 and 4 words) with a registered
// memory model, a UART responder and a timing-rule scoreboard per instance.
module tb_result_tx_streamer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic [7:0] exp_seq [8] = '{8'h22, 8'h11, 8'h44, 8'h33, 8'h66, 8'h55, 8'h88, 8'h77};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int NW = (g == 0) ? 1 : 4;

        result_tx_streamer_if #(.ADDR_W(16)) u_bus ();

        logic        start = 1'b0;
        logic        busy;
        logic        done;
        logic [31:0] byte_count;

        result_tx_streamer #(.NUM_WORDS(NW), .ADDR_W(16)) u_dut (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_start      (start),
            .bus          (u_bus.master),
            .o_busy       (busy),
            .o_done       (done),
            .o_byte_count (byte_count)
        );

        // Registered memory: data for an address appears one cycle later.
        logic [63:0] mem_w [4];
        always @(posedge clk)
            u_bus.mem_rd_data <= (u_bus.mem_addr < 16'd4) ? mem_w[u_bus.mem_addr[1:0]] : '0;

        // UART responder: tx_done a set number of cycles after tx_en.
        bit stall = 1'b0;
        bit coinc = 1'b0;
        bit inj   = 1'b0;
        bit rnd   = 1'b0;
        int dly   = 5;
        int cnt_u = 0;
        bit td_v;
        always @(posedge clk) begin
            #2;
            td_v = inj;
            if (!rst_n) begin
                cnt_u = 0;
            end else if (!stall && cnt_u > 0) begin
                cnt_u--;
                if (cnt_u == 0) td_v = 1'b1;
            end
            if (rst_n && u_bus.tx_en) begin
                if (coinc) td_v = 1'b1;
                if (cnt_u == 0) cnt_u = rnd ? int'($urandom_range(1, 6)) : dly;
            end
            u_bus.tx_done = td_v;
        end

        // Scoreboard: expected outputs from the byte order and latency rules.
        int          cnt_m     = 0;
        int          nb        = 0;
        int          en_due    = -1;
        int          done_due  = -1;
        int          pend_from = 0;
        int          obs_done  = 0;
        bit          busy_m    = 1'b0;
        bit          pend      = 1'b0;
        logic [7:0]  last_m    = '0;
        logic [7:0]  log_q [$];

        function automatic logic [7:0] exp_byte(input int j);
            logic [15:0] lane;
            lane = 16'(mem_w[j / 8] >> (16 * ((j % 8) / 2)));
            return (j % 2 == 1) ? lane[15:8] : lane[7:0];
        endfunction

        always @(negedge clk) begin
            if (!rst_n) begin
                cnt_m    = 0;
                nb       = 0;
                busy_m   = 1'b0;
                pend     = 1'b0;
                en_due   = -1;
                done_due = -1;
                last_m   = '0;
            end
            check_val($sformatf("i%0d busy", g), busy, busy_m);
            check_val($sformatf("i%0d done", g), done, cyc == done_due);
            check_val($sformatf("i%0d tx_en", g), u_bus.tx_en, cyc == en_due);
            check_val($sformatf("i%0d byte_count", g), byte_count, cnt_m);
            check_val($sformatf("i%0d mem_addr", g), u_bus.mem_addr,
                      ((cnt_m / 8) < NW) ? (cnt_m / 8) : (NW - 1));
            if (rst_n && u_bus.tx_en && nb < 8 * NW) begin
                last_m    = exp_byte(nb);
                nb++;
                pend      = 1'b1;
                pend_from = cyc + 1;
                log_q.push_back(u_bus.tx_data);
            end
            check_val($sformatf("i%0d tx_data", g), u_bus.tx_data, last_m);
            if (done) obs_done++;
            if (rst_n) begin
                if (!busy_m && start) begin
                    busy_m = 1'b1;
                    cnt_m  = 0;
                    nb     = 0;
                    en_due = cyc + 4;
                end else if (pend && u_bus.tx_done && cyc >= pend_from) begin
                    pend = 1'b0;
                    cnt_m++;
                    if (cnt_m % 8 != 0)     en_due   = cyc + 1;
                    else if (cnt_m < 8 * NW) en_due  = cyc + 4;
                    else                     done_due = cyc + 1;
                end else if (busy_m && cyc == done_due) begin
                    busy_m = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int k, input int target, input int budget);
        int got;
        for (int i = 0; i < budget; i++) begin
            tick();
            got = (k == 0) ? g_inst[0].obs_done : g_inst[1].obs_done;
            if (got >= target) break;
        end
        got = (k == 0) ? g_inst[0].obs_done : g_inst[1].obs_done;
        check_val($sformatf("i%0d done_pulses", k), got, target);
    endtask

    task automatic pulse_start1();
        g_inst[1].start = 1'b1;
        tick();
        g_inst[1].start = 1'b0;
    endtask

    initial begin
        int lim;
        rst_n = 1'b0;
        g_inst[0].mem_w[0] = 64'h7788_5566_3344_1122;
        for (int i = 1; i < 4; i++) g_inst[0].mem_w[i] = '0;
        for (int i = 0; i < 4; i++) g_inst[1].mem_w[i] = {$urandom, $urandom};
        g_inst[0].dly = 5;
        g_inst[1].rnd = 1'b1;

        // Reset held with start high, then release: both begin immediately.
        g_inst[0].start = 1'b1;
        g_inst[1].start = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        g_inst[0].start = 1'b0;
        g_inst[1].start = 1'b0;
        wait_done(0, 1, 500);
        wait_done(1, 1, 2000);
        check_val("i0 seq_len", g_inst[0].log_q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < g_inst[0].log_q.size())
                check_val($sformatf("i0 seq[%0d]", i), g_inst[0].log_q[i], exp_seq[i]);

        // Handshake abuse: tx_done in IDLE, in LATCH, with tx_en; start mid-transfer.
        for (int i = 0; i < 4; i++) g_inst[1].mem_w[i] = {$urandom, $urandom};
        g_inst[1].coinc = 1'b1;
        g_inst[1].inj = 1'b1;
        tick();
        g_inst[1].inj = 1'b0;
        pulse_start1();
        tick();
        g_inst[1].inj = 1'b1;
        tick();
        g_inst[1].inj = 1'b0;
        repeat (40) begin
            g_inst[1].start = ($urandom_range(0, 3) == 0);
            tick();
        end
        g_inst[1].start = 1'b0;
        wait_done(1, 2, 2000);
        g_inst[1].coinc = 1'b0;

        // Stall: tx_done withheld for 1000 cycles after the fifth byte.
        g_inst[1].rnd = 1'b0;
        g_inst[1].dly = 3;
        pulse_start1();
        lim = 0;
        while (g_inst[1].nb != 5 && lim < 300) begin
            tick();
            lim++;
        end
        check_val("i1 stall_sync", g_inst[1].nb, 5);
        g_inst[1].stall = 1'b1;
        repeat (1000) tick();
        g_inst[1].stall = 1'b0;
        wait_done(1, 3, 2000);

        // Reset after byte 3 of address 2, then a clean restart.
        g_inst[1].rnd = 1'b1;
        pulse_start1();
        lim = 0;
        while (g_inst[1].cnt_m != 20 && lim < 1000) begin
            tick();
            lim++;
        end
        check_val("i1 reset_sync", g_inst[1].cnt_m, 20);
        rst_n = 1'b0;
        #1;
        check_val("rst busy", g_inst[1].busy, 0);
        check_val("rst done", g_inst[1].done, 0);
        check_val("rst byte_count", g_inst[1].byte_count, 0);
        check_val("rst mem_addr", g_inst[1].u_bus.mem_addr, 0);
        check_val("rst tx_data", g_inst[1].u_bus.tx_data, 0);
        check_val("rst tx_en", g_inst[1].u_bus.tx_en, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        pulse_start1();
        wait_done(1, 4, 2000);

        // Start held high: back-to-back transfers; single word instance alongside.
        for (int i = 0; i < 4; i++) g_inst[1].mem_w[i] = {$urandom, $urandom};
        g_inst[0].rnd = 1'b1;
        g_inst[0].start = 1'b1;
        g_inst[1].start = 1'b1;
        tick();
        g_inst[0].start = 1'b0;
        wait_done(1, 5, 2000);
        wait_done(1, 6, 2000);
        g_inst[1].start = 1'b0;
        check_val("i0 done_total", g_inst[0].obs_done, 2);
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/result_tx_streamer.md
# result_tx_streamer

Drains the NPU output memory over the UART transmitter once processing completes. On `start` it walks output-memory addresses 0..NUM_WORDS-1. It reads the four 16-bit result lanes at each address and serialises them as 8 bytes: lane 0 first, low byte first within each lane. Each byte is handed to the UART with a one-cycle `tx_en` pulse, and the block waits for `tx_done` before presenting the next byte. It sits between the output result memory and the UART TX path, and replaces the fixed `txData` tap.

## Interface
- `NUM_WORDS`, 8192: number of output-memory addresses to stream (≥1).
- `ADDR_W`, 16: output-memory address width.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: level sampled in IDLE; high starts a transfer.
- `mem_addr` out ADDR_W: read address to the output memory.
- `mem_rd_data` in 4x16 (packed, lane 0 = bits [15:0]): result lanes; valid one cycle after `mem_addr`, since the memory output is registered.
- `tx_data` out 8: byte to transmit.
- `tx_en` out 1: one-cycle pulse requesting transmission of `tx_data`.
- `tx_done` in 1: one-cycle pulse from the UART when a byte has finished.
- `busy` out 1: high from `start` acceptance until `done`.
- `done` out 1: one-cycle pulse after the last byte's `tx_done`.
- `byte_count` out 32: bytes completed in the current or last transfer.

## Operation
- States:
  - IDLE
  - FETCH: address presented
  - WAIT_RD: memory latency
  - LATCH: capture 64-bit buffer
  - SEND: `tx_en` high
  - WAIT_TX
  - FIN
- IDLE, `start`=1: `mem_addr`←0, `byte_count`←0, `busy`←1, go to FETCH.
- Fetch sequence:
  - FETCH → WAIT_RD unconditionally.
  - WAIT_RD → LATCH: buffer ← `mem_rd_data`, byte index ← 0.
  - LATCH → SEND.
- SEND: `tx_en`=1 for exactly one cycle; `tx_data` = buffer byte at the current index. Go to WAIT_TX.
  - Byte index i selects lane i/2; low byte when i is even, high byte when i is odd.
- WAIT_TX: stay until `tx_done`=1. Then `byte_count`+1, and:
  - index<7: index+1, go to SEND.
  - index=7 and `mem_addr`<NUM_WORDS-1: `mem_addr`+1, go to FETCH.
  - index=7 and `mem_addr`=NUM_WORDS-1: go to FIN.
- FIN: `done`=1 for one cycle, `busy`←0, go to IDLE. `mem_addr` and `byte_count` hold their values.
- `tx_data` is held stable from the SEND cycle until the next SEND.
- Total bytes per transfer = NUM_WORDS×8 (65536 at default). The counter is 32 bits, so there is no wrap.
- Boundary rules:
  - `start` while `busy`: ignored.
  - `start` held high continuously: a new transfer begins in the cycle after FIN returns to IDLE.
  - `tx_done` outside WAIT_TX: ignored, including a `tx_done` in the same cycle as `tx_en`.
  - `tx_done` never arrives: the block waits indefinitely. There is no timeout.
  - `rst` low at any time: immediate return to IDLE and all outputs to reset values; the partial transfer is discarded.
  - NUM_WORDS=1: a single fetch, 8 bytes, then FIN.

## Timing
- Reset values:
  - `mem_addr`=0, `tx_data`=0, `byte_count`=0.
  - `tx_en`=0, `busy`=0, `done`=0.
- All outputs are registered.
- Start latency: `start` sampled at edge E0 → first `tx_en` high during the cycle after E3 (FETCH, WAIT_RD, LATCH, SEND).
- Byte-to-byte within an address: `tx_en` rises in the cycle after the edge that samples `tx_done`.
- Address-to-address: 4 cycles from the `tx_done` of byte 7 to the next `tx_en`.
- `done` asserts the cycle after the final `tx_done` is sampled. `busy` falls on the same edge that ends `done`.
- `byte_count` updates on the edge sampling `tx_done`.

## Test plan
- Reset check: hold `rst`=0 with `start`=1 → all outputs 0. Release reset → FETCH entered on the first edge with `start` high.
- Single-address run (NUM_WORDS=1): memory returns lanes {0x1122, 0x3344, 0x5566, 0x7788}, and the UART model returns `tx_done` 5 cycles after each `tx_en`.
  - Required bytes, in order: 22 11 44 33 66 55 88 77.
  - `done` pulses once; `byte_count`=8.
- Multi-address run (NUM_WORDS=4): lane data = address-dependent pattern.
  - `mem_addr` sequence 0, 1, 2, 3.
  - 32 bytes in order; exactly 4 cycles between byte 7's `tx_done` and the next `tx_en`.
  - `byte_count`=32 at `done`.
- Handshake abuse: `tx_done` pulses in IDLE, in LATCH, and coincident with `tx_en` → no state advance, `byte_count` unchanged. A `start` pulse mid-transfer → ignored.
- Stall: `tx_done` withheld 1000 cycles → `tx_en` stays low, `tx_data` stable, `busy` stays 1.
- Reset mid-operation: assert `rst` after byte 3 of address 2.
  - All outputs go to 0 immediately.
  - A subsequent `start` restarts from `mem_addr`=0 with `byte_count`=0.
